clk_div_gen: RTL

Parametrised multi-channel generated-clock source. It is the successor to the pass-through clock manager used in the generated-clock timing benchmarks. Each channel divides the input clock by a runtime-programmable integer ratio, with programmable phase offset, enable and glitch-free ratio update. A lock indicator models PLL/MMCM lock. Outputs are registered, so each clkout is a clean pin target for create_generated_clock -source [get_ports clk] -divide_by R.

---
 rtl/clk_div_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with phase offset, per-channel
// enable, glitch-free ratio update at period boundaries and a lock indicator.
module clk_div_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEF_DIV     = 2,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         en,
  input  logic [NUM_CH*CNT_W-1:0]   div_ratio,
  input  logic [NUM_CH*CNT_W-1:0]   phase,
  input  logic                      load,
  output logic                      busy,
  output logic [NUM_CH-1:0]         clkout,
  output logic [NUM_CH-1:0]         tick,
  output logic                      locked
);

  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q        [NUM_CH];
  logic [CNT_W-1:0] cnt_d        [NUM_CH];
  logic [CNT_W-1:0] ratio_q      [NUM_CH];
  logic [CNT_W-1:0] ratio_d      [NUM_CH];
  logic [CNT_W-1:0] pend_ratio_q [NUM_CH];
  logic [CNT_W-1:0] pend_ratio_d [NUM_CH];
  logic [CNT_W-1:0] pend_phase_q [NUM_CH];
  logic [CNT_W-1:0] pend_phase_d [NUM_CH];
  logic [CNT_W-1:0] req_ratio    [NUM_CH];
  logic [CNT_W-1:0] req_phase    [NUM_CH];
  logic [CNT_W-1:0] san_ratio    [NUM_CH];
  logic [CNT_W:0]   half         [NUM_CH];
  logic [NUM_CH-1:0] at_end;

  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clkout_q, clkout_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              busy_q, busy_d;
  logic              locked_q, locked_d;
  logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
  logic              accept;

  // Per-channel counter, output waveform, pending capture and boundary update.
  always_comb begin
    accept = load & ~busy_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]        = cnt_q[i];
      ratio_d[i]      = ratio_q[i];
      pend_d[i]       = pend_q[i];
      pend_ratio_d[i] = pend_ratio_q[i];
      pend_phase_d[i] = pend_phase_q[i];
      clkout_d[i]     = 1'b0;
      tick_d[i]       = 1'b0;

      req_ratio[i] = div_ratio[i*CNT_W +: CNT_W];
      req_phase[i] = phase[i*CNT_W +: CNT_W];
      // Ratios below 2 cannot produce a toggling clock; clamp to 2.
      san_ratio[i] = (req_ratio[i] < CNT_W'(2)) ? CNT_W'(2) : req_ratio[i];

      // High time is ceil(R/2); one extra bit keeps R+1 from wrapping.
      half[i]   = ({1'b0, ratio_q[i]} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
      at_end[i] = (cnt_q[i] == ratio_q[i] - 1'b1);

      if (en[i]) begin
        clkout_d[i] = ({1'b0, cnt_q[i]} < half[i]);
        tick_d[i]   = (cnt_q[i] == '0);
        if (pend_q[i] && at_end[i]) begin
          ratio_d[i] = pend_ratio_q[i];
          cnt_d[i]   = pend_phase_q[i];
          pend_d[i]  = 1'b0;
        end else if (at_end[i]) begin
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
        // A stopped channel has no boundary to protect, so apply at once.
        if (pend_q[i]) begin
          ratio_d[i] = pend_ratio_q[i];
          pend_d[i]  = 1'b0;
        end
      end

      // busy_q low guarantees no flag is set, so capture never races an apply.
      if (accept) begin
        pend_d[i]       = 1'b1;
        pend_ratio_d[i] = san_ratio[i];
        pend_phase_d[i] = (req_phase[i] >= san_ratio[i]) ? '0 : req_phase[i];
      end
    end
  end

  // Busy tracks pending flags one edge late; lock counts idle edges.
  always_comb begin
    busy_d     = accept | (|pend_q);
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;
    if (accept) begin
      locked_d   = 1'b0;
      lock_cnt_d = '0;
    end else if (!busy_q && !locked_q) begin
      if (lock_cnt_q == LockW'(LOCK_CYCLES - 1)) begin
        locked_d = 1'b1;
      end else begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]        <= '0;
        ratio_q[i]      <= CNT_W'(DEF_DIV);
        pend_ratio_q[i] <= CNT_W'(DEF_DIV);
        pend_phase_q[i] <= '0;
      end
      pend_q   <= '0;
      clkout_q <= '0;
      tick_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]        <= cnt_d[i];
        ratio_q[i]      <= ratio_d[i];
        pend_ratio_q[i] <= pend_ratio_d[i];
        pend_phase_q[i] <= pend_phase_d[i];
      end
      pend_q   <= pend_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
    end
  end

  // Global handshake and lock registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign busy   = busy_q;
  assign clkout = clkout_q;
  assign tick   = tick_q;
  assign locked = locked_q;

endmodule
